// File: rtl/get_command_fsm_param.sv
// ---------------------------------------------------------------------------
// get_command_fsm_param
//
// Command fetch/decode FSM for the polynomial evaluation accelerator.
// A start pulse taken in IDLE reads one word from the command buffer.
// The word is split into three fields: opcode (MSBs), arg1, and arg2 (LSBs).
// The read address advances by one per successful fetch and wraps at
// BUFFER_SIZE.
//
// Handshake: start_get_cmd is a level that is only looked at in IDLE. Every
// accepted start produces exactly one done_get_cmd pulse, unless rst
// intervenes. en_rd_cmd is a one-cycle request to the buffer, which must
// present read data RD_LATENCY cycles later. If no command is available,
// done_get_cmd comes back with cmd_empty set and nothing is read.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start_get_cmd     fetch request (IDLE only)
//   cmd_count         unread commands in the buffer (sampled in IDLE)
//   command           buffer read data
//   en_rd_cmd         buffer read enable pulse
//   rd_addr_command   registered buffer read address
//   done_get_cmd      completion pulse
//   cmd_empty         completion was for an empty buffer
//   busy              FSM not in IDLE
//   instr/arg1/arg2   registered decoded fields
//   illegal_instr     only with GET_CMD_ILLEGAL_CHECK_EN
//
// Optional feature macro: GET_CMD_ILLEGAL_CHECK_EN. When it is defined,
// opcodes >= NUM_OPCODES are replaced by all ones (NOP) and flagged.
//
// BUFFER_SIZE must be a power of two (>= 2). RD_LATENCY must be 1..4.
// ---------------------------------------------------------------------------
module get_command_fsm_param #(
    parameter int BUFFER_SIZE = 1024,
    parameter int CMD_WIDTH   = 16,
    parameter int INSTR_WIDTH = 8,
    parameter int ARG1_WIDTH  = 3,
    parameter int ARG2_WIDTH  = 5,
    parameter int RD_LATENCY  = 1,
    parameter int NUM_OPCODES = 16,
    localparam int AW         = $clog2(BUFFER_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_get_cmd,
    input  logic [AW:0]            cmd_count,
    input  logic [CMD_WIDTH-1:0]   command,
    output logic                   en_rd_cmd,
    output logic [AW-1:0]          rd_addr_command,
    output logic                   done_get_cmd,
    output logic                   cmd_empty,
    output logic                   busy,
`ifdef GET_CMD_ILLEGAL_CHECK_EN
    output logic                   illegal_instr,
`endif
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ARG1_WIDTH-1:0]  arg1,
    output logic [ARG2_WIDTH-1:0]  arg2
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // WAIT spans RD_LATENCY-1 cycles. The counter runs 0..WAIT_LAST.
    // With RD_LATENCY == 1, WAIT is never entered and the value is unused.
    localparam int          WAIT_LAST   = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
    localparam logic [1:0]  WAIT_LAST_C = 2'(WAIT_LAST);

    state_e                 state_q, state_d;
    logic [AW-1:0]          rd_addr_q, rd_addr_d;
    logic [1:0]             wait_cnt_q, wait_cnt_d;
    logic                   empty_q, empty_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ARG1_WIDTH-1:0]  arg1_q, arg1_d;
    logic [ARG2_WIDTH-1:0]  arg2_q, arg2_d;

    logic [INSTR_WIDTH-1:0] cmd_instr;
    logic [ARG1_WIDTH-1:0]  cmd_arg1;
    logic [ARG2_WIDTH-1:0]  cmd_arg2;

    assign cmd_instr = command[CMD_WIDTH-1 -: INSTR_WIDTH];
    assign cmd_arg1  = command[ARG2_WIDTH +: ARG1_WIDTH];
    assign cmd_arg2  = command[ARG2_WIDTH-1:0];

`ifdef GET_CMD_ILLEGAL_CHECK_EN
    // One extra bit, so that NUM_OPCODES == 2**INSTR_WIDTH still compares correctly.
    localparam logic [INSTR_WIDTH:0] NUM_OP_C = (INSTR_WIDTH+1)'(NUM_OPCODES);
    logic illegal_q, illegal_d;
`endif

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        wait_cnt_d = wait_cnt_q;
        empty_d    = empty_q;
        instr_d    = instr_q;
        arg1_d     = arg1_q;
        arg2_d     = arg2_q;
`ifdef GET_CMD_ILLEGAL_CHECK_EN
        illegal_d  = illegal_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_get_cmd) begin
                    // The empty decision is latched here. A later change of
                    // cmd_count cannot alter a fetch that is already in progress.
                    empty_d = (cmd_count == '0);
                    if (cmd_count == '0) begin
                        state_d = S_DONE;
`ifdef GET_CMD_ILLEGAL_CHECK_EN
                        illegal_d = 1'b0;
`endif
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = (RD_LATENCY == 1) ? S_DECODE : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST_C) begin
                    state_d = S_DECODE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_DECODE: begin
                instr_d   = cmd_instr;
                arg1_d    = cmd_arg1;
                arg2_d    = cmd_arg2;
`ifdef GET_CMD_ILLEGAL_CHECK_EN
                illegal_d = ({1'b0, cmd_instr} >= NUM_OP_C);
                if ({1'b0, cmd_instr} >= NUM_OP_C) begin
                    instr_d = '1;
                end
`endif
                // A power-of-two depth makes the natural overflow the wrap.
                rd_addr_d = rd_addr_q + AW'(1);
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            wait_cnt_q <= '0;
            empty_q    <= 1'b0;
            instr_q    <= '1;
            arg1_q     <= '0;
            arg2_q     <= '0;
`ifdef GET_CMD_ILLEGAL_CHECK_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            wait_cnt_q <= wait_cnt_d;
            empty_q    <= empty_d;
            instr_q    <= instr_d;
            arg1_q     <= arg1_d;
            arg2_q     <= arg2_d;
`ifdef GET_CMD_ILLEGAL_CHECK_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    // All pulse outputs are decoded from registered state.
    assign en_rd_cmd       = (state_q == S_ISSUE);
    assign done_get_cmd    = (state_q == S_DONE);
    assign cmd_empty       = (state_q == S_DONE) && empty_q;
    assign busy            = (state_q != S_IDLE);
    assign rd_addr_command = rd_addr_q;
    assign instr           = instr_q;
    assign arg1            = arg1_q;
    assign arg2            = arg2_q;
`ifdef GET_CMD_ILLEGAL_CHECK_EN
    assign illegal_instr   = illegal_q;
`endif

endmodule

// File: tb/tb_get_command_fsm_param.sv
// Bench for get_command_fsm_param. It drives two instances in lockstep:
//   A: default parameters (1024 deep, read latency 1)
//   B: 4-deep buffer, read latency 3
// Both instances are checked against a transaction-level model.
module tb_get_command_fsm_param;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int BS_A  = 1024;
  localparam int BS_B  = 4;
  localparam int STEPS = 2 + LAT_B + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [10:0] cc_a = '0;
  logic [2:0]  cc_b = '0;
  logic [15:0] cmd_a, cmd_b;

  logic en_a, done_a, empty_a, busy_a;
  logic en_b, done_b, empty_b, busy_b;
  logic [9:0] addr_a;
  logic [1:0] addr_b;
  logic [7:0] instr_a, instr_b;
  logic [2:0] arg1_a, arg1_b;
  logic [4:0] arg2_a, arg2_b;
  logic ill_a, ill_b;

  always #5 clk = ~clk;

  get_command_fsm_param #(.BUFFER_SIZE(BS_A), .RD_LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .start_get_cmd(start), .cmd_count(cc_a), .command(cmd_a),
    .en_rd_cmd(en_a), .rd_addr_command(addr_a), .done_get_cmd(done_a),
    .cmd_empty(empty_a), .busy(busy_a),
`ifdef GET_CMD_ILLEGAL_CHECK_EN
    .illegal_instr(ill_a),
`endif
    .instr(instr_a), .arg1(arg1_a), .arg2(arg2_a)
  );

  get_command_fsm_param #(.BUFFER_SIZE(BS_B), .RD_LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .start_get_cmd(start), .cmd_count(cc_b), .command(cmd_b),
    .en_rd_cmd(en_b), .rd_addr_command(addr_b), .done_get_cmd(done_b),
    .cmd_empty(empty_b), .busy(busy_b),
`ifdef GET_CMD_ILLEGAL_CHECK_EN
    .illegal_instr(ill_b),
`endif
    .instr(instr_b), .arg1(arg1_b), .arg2(arg2_b)
  );

`ifndef GET_CMD_ILLEGAL_CHECK_EN
  assign ill_a = 1'b0;
  assign ill_b = 1'b0;
`endif

  // Buffer model. Read data is valid exactly RD_LATENCY cycles after the enable.
  // In every other cycle the data is random garbage.
  logic [15:0] mem [1024];
  logic [15:0] pa;
  logic [15:0] pb [3];
  always @(posedge clk) begin
    pa    <= en_a ? mem[addr_a] : 16'($urandom);
    pb[0] <= en_b ? mem[{8'd0, addr_b}] : 16'($urandom);
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign cmd_a = pa;
  assign cmd_b = pb[2];

  // Indexed views of both instances.
  logic       en_o [2], done_o [2], empty_o [2], busy_o [2], ill_o [2];
  logic [9:0] addr_o [2];
  logic [7:0] instr_o [2];
  logic [2:0] arg1_o [2];
  logic [4:0] arg2_o [2];
  assign en_o[0] = en_a;       assign en_o[1] = en_b;
  assign done_o[0] = done_a;   assign done_o[1] = done_b;
  assign empty_o[0] = empty_a; assign empty_o[1] = empty_b;
  assign busy_o[0] = busy_a;   assign busy_o[1] = busy_b;
  assign ill_o[0] = ill_a;     assign ill_o[1] = ill_b;
  assign addr_o[0] = addr_a;   assign addr_o[1] = {8'd0, addr_b};
  assign instr_o[0] = instr_a; assign instr_o[1] = instr_b;
  assign arg1_o[0] = arg1_a;   assign arg1_o[1] = arg1_b;
  assign arg2_o[0] = arg2_a;   assign arg2_o[1] = arg2_b;

  // Reference model state
  int         lat [2] = '{LAT_A, LAT_B};
  int         bs  [2] = '{BS_A, BS_B};
  int         exp_addr [2];
  logic [7:0] exp_instr [2];
  logic [2:0] exp_arg1 [2];
  logic [4:0] exp_arg2 [2];
  logic       exp_ill [2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      exp_addr[i]  = 0;
      exp_instr[i] = 8'hFF;
      exp_arg1[i]  = 3'd0;
      exp_arg2[i]  = 5'd0;
      exp_ill[i]   = 1'b0;
    end
  endtask

  // Model of one fetch: the decode rules applied to the word at the current address.
  task automatic model_fetch(input int i, input bit empty);
    logic [15:0] c;
    if (empty) begin
      exp_ill[i] = 1'b0;
    end else begin
      c            = mem[exp_addr[i]];
      exp_instr[i] = c[15:8];
      exp_arg1[i]  = c[7:5];
      exp_arg2[i]  = c[4:0];
      exp_ill[i]   = 1'b0;
`ifdef GET_CMD_ILLEGAL_CHECK_EN
      if (c[15:8] >= 8'd16) begin
        exp_instr[i] = 8'hFF;
        exp_ill[i]   = 1'b1;
      end
`endif
      exp_addr[i] = (exp_addr[i] + 1) % bs[i];
    end
  endtask

  // One start request, observed for STEPS cycles. hold keeps start high while
  // instance A is still busy. cmd_count is scrambled after acceptance.
  task automatic do_fetch(input int cc, input bit hold);
    bit   empty;
    int   en_cnt [2], en_t [2], en_addr [2], done_cnt [2], done_t [2], busy_bad [2], edone [2];
    logic emp_at_done [2];
    logic [7:0] instr_at [2];
    logic [2:0] arg1_at [2];
    logic [4:0] arg2_at [2];
    empty = (cc == 0);
    for (int i = 0; i < 2; i++) begin
      en_cnt[i] = 0; en_t[i] = 0; en_addr[i] = 0; done_cnt[i] = 0; done_t[i] = 0;
      busy_bad[i] = 0; emp_at_done[i] = 1'b0;
      instr_at[i] = '0; arg1_at[i] = '0; arg2_at[i] = '0;
      edone[i] = empty ? 1 : 2 + lat[i];
    end
    @(negedge clk);
    start = 1'b1;
    cc_a  = 11'(cc);
    cc_b  = 3'(cc);
    for (int t = 1; t <= STEPS; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (en_o[i]) begin
          en_cnt[i]++;
          if (en_cnt[i] == 1) begin
            en_t[i]    = t;
            en_addr[i] = int'(addr_o[i]);
          end
        end
        if (done_o[i]) begin
          done_cnt[i]++;
          done_t[i]      = t;
          emp_at_done[i] = empty_o[i];
          instr_at[i]    = instr_o[i];
          arg1_at[i]     = arg1_o[i];
          arg2_at[i]     = arg2_o[i];
        end
        if (busy_o[i] !== (t <= edone[i])) busy_bad[i]++;
      end
      if (!hold || t >= edone[0]) start = 1'b0;
      cc_a = 11'($urandom_range(0, 4));
      cc_b = 3'(cc_a);
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("en_count[%0d]", i), en_cnt[i], empty ? 0 : 1);
      if (!empty) begin
        check($sformatf("en_cycle[%0d]", i), en_t[i], 1);
        check($sformatf("rd_addr_at_en[%0d]", i), en_addr[i], exp_addr[i]);
      end
      model_fetch(i, empty);
      check($sformatf("done_count[%0d]", i), done_cnt[i], 1);
      check($sformatf("done_cycle[%0d]", i), done_t[i], edone[i]);
      check($sformatf("cmd_empty_at_done[%0d]", i), emp_at_done[i], empty);
      check($sformatf("instr_at_done[%0d]", i), instr_at[i], exp_instr[i]);
      check($sformatf("arg1_at_done[%0d]", i), arg1_at[i], exp_arg1[i]);
      check($sformatf("arg2_at_done[%0d]", i), arg2_at[i], exp_arg2[i]);
      check($sformatf("busy_profile[%0d]", i), busy_bad[i], 0);
      check($sformatf("rd_addr_after[%0d]", i), addr_o[i], exp_addr[i]);
      check($sformatf("instr_after[%0d]", i), instr_o[i], exp_instr[i]);
`ifdef GET_CMD_ILLEGAL_CHECK_EN
      check($sformatf("illegal_after[%0d]", i), ill_o[i], exp_ill[i]);
`endif
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_instr[%0d]", tag, i), instr_o[i], 8'hFF);
      check($sformatf("%s_arg1[%0d]", tag, i), arg1_o[i], 0);
      check($sformatf("%s_arg2[%0d]", tag, i), arg2_o[i], 0);
      check($sformatf("%s_addr[%0d]", tag, i), addr_o[i], 0);
      check($sformatf("%s_pulses[%0d]", tag, i),
            {en_o[i], done_o[i], empty_o[i], busy_o[i], ill_o[i]}, 0);
    end
  endtask

  initial begin
    int idle_bad;
    int done_seen;
    for (int k = 0; k < 1024; k++) mem[k] = 16'($urandom);
    mem[0] = 16'h05A3;

    // Reset, then 5 idle cycles
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_model();
    idle_bad = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (en_o[i] || done_o[i] || busy_o[i]) idle_bad++;
    end
    check("idle_quiet", idle_bad, 0);
    check_reset_values("post_reset");

    // Directed fetch of 16'h05A3 from address 0
    do_fetch(3, 1'b0);
    check("dir_instr_a", instr_a, 8'h05);
    check("dir_arg1_a", arg1_a, 3'b101);
    check("dir_arg2_a", arg2_a, 5'b00011);
    check("dir_addr_a", addr_a, 1);
    check("dir_instr_b", instr_b, 8'h05);

    // Empty buffer, then start held high through busy
    do_fetch(0, 1'b0);
    do_fetch(2, 1'b1);
    do_fetch(4, 1'b0);

    // B now sits at address 3. Four fetches should read 3,0,1,2.
    check("wrap_start_b", addr_b, 2'd3);
    for (int k = 0; k < 4; k++) do_fetch(1, 1'b0);
    check("wrap_end_b", addr_b, 2'd3);

    // Out-of-range opcode
    mem[exp_addr[0]] = 16'h2A41;
    mem[exp_addr[1]] = 16'h2A41;
    do_fetch(1, 1'b0);
`ifdef GET_CMD_ILLEGAL_CHECK_EN
    check("illegal_instr_b", instr_b, 8'hFF);
    check("illegal_flag_b", ill_b, 1'b1);
`else
    check("passthru_instr_b", instr_b, 8'h2A);
`endif
    check("illegal_arg1_b", arg1_b, 3'b010);
    check("illegal_arg2_b", arg2_b, 5'b00001);

    // Reset asserted while B is in WAIT and A is in DECODE
    done_seen = 0;
    @(negedge clk);
    start = 1'b1;
    cc_a = 11'd2;
    cc_b = 3'd2;
    @(negedge clk);
    start = 1'b0;
    if (done_a || done_b) done_seen++;
    @(negedge clk);
    if (done_a || done_b) done_seen++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    check_reset_values("mid_reset");
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (done_a || done_b) done_seen++;
    end
    check("mid_reset_no_done", done_seen, 0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        mem[exp_addr[0]] = {8'($urandom_range(0, 31)), 8'($urandom)};
        mem[exp_addr[1]] = {8'($urandom_range(0, 31)), 8'($urandom)};
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_fetch(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 4)),
               1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
